// File: rtl/flt2fix_seq_if.sv
// Shared data-memory port used by the flt2fix_seq sequencer (req/gnt handshake,
// byte-wide combinational read, gated write strobe).
interface flt2fix_seq_if #(
  parameter int unsigned AW = 8
);
  logic          mem_req;
  logic          mem_gnt;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rd_data;
  logic          mem_wr_en;
  logic [7:0]    mem_wr_data;

  modport master (
    output mem_req, mem_addr, mem_wr_en, mem_wr_data,
    input  mem_gnt, mem_rd_data
  );

  modport slave (
    input  mem_req, mem_addr, mem_wr_en, mem_wr_data,
    output mem_gnt, mem_rd_data
  );
endinterface

// File: rtl/flt2fix_seq.sv
// Half-precision float -> signed 8.8 fixed-point sequencer on a shared byte memory.
// Define FLT2FIX_ROUND_EN for round-to-nearest-even instead of truncation.
module flt2fix_seq #(
  parameter int unsigned SRC_ADDR = 4,
  parameter int unsigned DST_ADDR = 6,
  parameter int unsigned AW       = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                done,
  output logic                busy,
  flt2fix_seq_if.master       mem
);

  typedef enum logic [3:0] {
    IDLE, RD_LO, RD_HI, CLASSIFY, SHIFT, SIGN, WR_LO, WR_HI, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  lo_q, hi_q;
  logic        sgn_q;
  logic [15:0] mag_q;
  logic [3:0]  cnt_q;
  logic        left_q;
  logic [15:0] res_q;

  logic        f_sgn;
  logic [4:0]  f_exp;
  logic [10:0] f_man;
  logic [15:0] cls_mag;
  logic [3:0]  cls_n;
  logic        cls_left;
  logic [15:0] rnd_mag;
  logic [15:0] sgn_res;

  assign f_sgn = hi_q[7];
  assign f_exp = hi_q[6:2];
  assign f_man = {|f_exp, hi_q[1:0], lo_q};

  // Value is man * 2^(exp-17) in 8.8 units; exp<5 would need more than 12 right shifts.
  always_comb begin
    cls_mag  = '0;
    cls_n    = '0;
    cls_left = 1'b0;
    if (f_exp >= 5'd23) begin
      cls_mag = f_sgn ? 16'h8000 : 16'h7FFF;
    end else if (f_exp >= 5'd17) begin
      cls_mag  = {5'b0, f_man};
      cls_n    = 4'(f_exp - 5'd17);
      cls_left = 1'b1;
    end else if (f_exp >= 5'd5) begin
      cls_mag = {5'b0, f_man};
      cls_n   = 4'(5'd17 - f_exp);
    end
  end

`ifdef FLT2FIX_ROUND_EN
  logic guard_q, sticky_q;
  assign rnd_mag = mag_q + {15'b0, guard_q & (sticky_q | mag_q[0])};
`else
  assign rnd_mag = mag_q;
`endif

  always_comb begin
    if (rnd_mag > 16'h7FFF) sgn_res = sgn_q ? 16'h8000 : 16'h7FFF;
    else                    sgn_res = sgn_q ? (~rnd_mag + 16'd1) : rnd_mag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_q     <= '0;
      hi_q     <= '0;
      sgn_q    <= 1'b0;
      mag_q    <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      res_q    <= '0;
`ifdef FLT2FIX_ROUND_EN
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        RD_LO: if (mem.mem_gnt) lo_q <= mem.mem_rd_data;
        RD_HI: if (mem.mem_gnt) hi_q <= mem.mem_rd_data;
        CLASSIFY: begin
          sgn_q  <= f_sgn;
          mag_q  <= cls_mag;
          cnt_q  <= cls_n;
          left_q <= cls_left;
`ifdef FLT2FIX_ROUND_EN
          guard_q  <= 1'b0;
          sticky_q <= 1'b0;
`endif
        end
        SHIFT: begin
          cnt_q <= cnt_q - 4'd1;
          if (left_q) begin
            mag_q <= {mag_q[14:0], 1'b0};
          end else begin
            mag_q <= {1'b0, mag_q[15:1]};
`ifdef FLT2FIX_ROUND_EN
            // Guard holds the most recent bit shifted out, sticky the OR of all older ones.
            guard_q  <= mag_q[0];
            sticky_q <= sticky_q | guard_q;
`endif
          end
        end
        SIGN:    res_q <= sgn_res;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d         = state_q;
    mem.mem_req     = 1'b0;
    mem.mem_addr    = '0;
    mem.mem_wr_en   = 1'b0;
    mem.mem_wr_data = '0;
    done            = 1'b0;
    busy            = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = RD_LO;
      end
      RD_LO: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = AW'(SRC_ADDR);
        if (mem.mem_gnt) state_d = RD_HI;
      end
      RD_HI: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = AW'(SRC_ADDR + 1);
        if (mem.mem_gnt) state_d = CLASSIFY;
      end
      CLASSIFY: state_d = (cls_n == 4'd0) ? SIGN : SHIFT;
      SHIFT:    if (cnt_q == 4'd1) state_d = SIGN;
      SIGN:     state_d = WR_LO;
      WR_LO: begin
        mem.mem_req     = 1'b1;
        mem.mem_addr    = AW'(DST_ADDR);
        mem.mem_wr_data = res_q[7:0];
        mem.mem_wr_en   = mem.mem_gnt;
        if (mem.mem_gnt) state_d = WR_HI;
      end
      WR_HI: begin
        mem.mem_req     = 1'b1;
        mem.mem_addr    = AW'(DST_ADDR + 1);
        mem.mem_wr_data = res_q[15:8];
        mem.mem_wr_en   = mem.mem_gnt;
        if (mem.mem_gnt) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        busy = 1'b0;
        if (start) state_d = RD_LO;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_flt2fix_seq.sv
// Self-checking bench for flt2fix_seq: directed vectors, gnt stalls, reset abort,
// and randomized floats/grants against an arithmetic reference model.
module tb_flt2fix_seq;

`ifdef FLT2FIX_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        done, busy;
  logic [15:0] src = 16'h0000;
  logic [7:0]  dst_lo, dst_hi;
  logic        clr_dst = 1'b0;
  logic [15:0] exp_res = 16'h0000;
  int          total = 0;
  int          bad = 0;

  flt2fix_seq_if #(.AW(8)) mif ();

  flt2fix_seq #(.SRC_ADDR(4), .DST_ADDR(6), .AW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .done  (done),
    .busy  (busy),
    .mem   (mif.master)
  );

  always #5 clk = ~clk;

  assign mif.mem_rd_data = (mif.mem_addr == 8'd4) ? src[7:0] :
                           (mif.mem_addr == 8'd5) ? src[15:8] : 8'h5A;

  always @(posedge clk) begin
    if (clr_dst) begin
      dst_lo <= 8'hAA;
      dst_hi <= 8'hAA;
    end else if (mif.mem_wr_en && mif.mem_gnt) begin
      if (mif.mem_addr == 8'd6)      dst_lo <= mif.mem_wr_data;
      else if (mif.mem_addr == 8'd7) dst_hi <= mif.mem_wr_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Exact value m*2^(e-17), optionally rounded half-to-even, then clamped to int16.
  function automatic logic [15:0] model(input logic [15:0] h, input bit rnd);
    int e, m, mag, v, sh, rem, half;
    e = int'(h[14:10]);
    m = int'(h[9:0]) + ((e != 0) ? 1024 : 0);
    if (e == 31) mag = 1 << 20;
    else if (e >= 17) mag = m << (e - 17);
    else begin
      sh  = 17 - e;
      mag = m >> sh;
      if (rnd) begin
        rem  = m - (mag << sh);
        half = 1 << (sh - 1);
        if (rem > half || (rem == half && (mag % 2) == 1)) mag++;
      end
    end
    v = h[15] ? -mag : mag;
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return 16'(v);
  endfunction

  function automatic int nshift(input logic [15:0] h);
    int e;
    e = int'(h[14:10]);
    if (e >= 23) return 0;
    if (e >= 17) return e - 17;
    if (17 - e > 12) return 0;
    return 17 - e;
  endfunction

  // Write checker: every write must be granted and carry the expected byte.
  always @(negedge clk) begin
    if (reset) chk("wr_in_reset", mif.mem_wr_en, 1'b0);
    if (mif.mem_wr_en) begin
      chk("wr_gnt", mif.mem_gnt, 1'b1);
      chk("wr_req", mif.mem_req, 1'b1);
      if (mif.mem_addr == 8'd6)      chk("wr_lo_data", mif.mem_wr_data, exp_res[7:0]);
      else if (mif.mem_addr == 8'd7) chk("wr_hi_data", mif.mem_wr_data, exp_res[15:8]);
      else                           chk("wr_addr", mif.mem_addr, 8'd6);
    end
    if (done) chk("done_busy_excl", busy, 1'b0);
  end

  // mode 0: gnt tied high; 1: random gnt and stray starts; 2: 3-cycle stalls on RD_HI and WR_LO
  task automatic run_job(input logic [15:0] h, input int mode, input int busy_start_at,
                         output int lat);
    int srd, swr;
    srd = 0; swr = 0;
    src = h;
    exp_res = model(h, RND);
    clr_dst = 1'b1;
    @(posedge clk); #2;
    clr_dst = 1'b0;
    mif.mem_gnt = 1'b1;
    start = 1'b1;
    @(posedge clk); lat = 1; #2;
    start = 1'b0;
    chk("done_drop", done, 1'b0);
    while (!done && lat < 300) begin
      case (mode)
        1: begin
          mif.mem_gnt = 1'($urandom_range(0, 1));
          start = busy && ($urandom_range(0, 5) == 0);
        end
        2: begin
          if (mif.mem_req && mif.mem_addr == 8'd5 && srd < 3) begin
            mif.mem_gnt = 1'b0; srd++;
          end else if (mif.mem_req && mif.mem_addr == 8'd6 && swr < 3) begin
            mif.mem_gnt = 1'b0; swr++;
          end else mif.mem_gnt = 1'b1;
        end
        default: mif.mem_gnt = 1'b1;
      endcase
      if (mode != 1) start = (lat == busy_start_at);
      @(posedge clk); lat++; #2;
    end
    start = 1'b0;
    mif.mem_gnt = 1'b1;
    chk("job_timeout", done, 1'b1);
    chk("done_busy", busy, 1'b0);
    chk("result", {dst_hi, dst_lo}, exp_res);
  endtask

  typedef struct { logic [15:0] h; logic [15:0] want; } vec_t;
  vec_t vecs[$];

  initial begin
    int lat;
    logic [15:0] h;
    mif.mem_gnt = 1'b1;

    // Pin the model to hand-worked values.
    chk("model_1p0",  model(16'h3C00, RND), 16'h0100);
    chk("model_1p25", model(16'h3D00, RND), 16'h0140);
    chk("model_m1",   model(16'hBC00, RND), 16'hFF00);
    chk("model_lsb",  model(16'h1E00, RND), RND ? 16'h0002 : 16'h0001);
    chk("model_inf",  model(16'hFC00, RND), 16'h8000);

    #1;
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req",  mif.mem_req, 1'b0);
    chk("rst_wren", mif.mem_wr_en, 1'b0);
    chk("rst_addr", mif.mem_addr, 8'h00);
    chk("rst_wdat", mif.mem_wr_data, 8'h00);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    vecs = '{
      '{16'h3C00, 16'h0100}, '{16'h3D00, 16'h0140}, '{16'hBC00, 16'hFF00},
      '{16'h4400, 16'h0400}, '{16'h5B00, 16'h7FFF}, '{16'hD800, 16'h8000},
      '{16'h7800, 16'h7FFF}, '{16'hF800, 16'h8000}, '{16'h8000, 16'h0000},
      '{16'h0001, 16'h0000}, '{16'h7C00, 16'h7FFF}, '{16'hFE00, 16'h8000},
      '{16'h1E00, RND ? 16'h0002 : 16'h0001}
    };
    foreach (vecs[i]) begin
      run_job(vecs[i].h, 0, -1, lat);
      chk($sformatf("lit_%04h", vecs[i].h), {dst_hi, dst_lo}, vecs[i].want);
      chk($sformatf("lat_%04h", vecs[i].h), lat, 7 + nshift(vecs[i].h));
    end
    chk("lat_1p0_lit", nshift(16'h3C00), 2);

    // gnt stalls on RD_HI and WR_LO add exactly six cycles
    run_job(16'h3C00, 2, -1, lat);
    chk("stall_res", {dst_hi, dst_lo}, 16'h0100);
    chk("stall_lat", lat, 15);

    // start while busy is ignored
    run_job(16'h3D00, 0, 4, lat);
    chk("busy_start_res", {dst_hi, dst_lo}, 16'h0140);
    chk("busy_start_lat", lat, 9);

    // reset during SHIFT aborts with no writes
    src = 16'h1E00;
    exp_res = model(16'h1E00, RND);
    clr_dst = 1'b1;
    @(posedge clk); #2;
    clr_dst = 1'b0;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_done", done, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_req",  mif.mem_req, 1'b0);
    chk("abort_wren", mif.mem_wr_en, 1'b0);
    chk("abort_addr", mif.mem_addr, 8'h00);
    chk("abort_wdat", mif.mem_wr_data, 8'h00);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("abort_dst", {dst_hi, dst_lo}, 16'hAAAA);
    chk("abort_idle", busy, 1'b0);

    // randomized floats with random grants and stray starts
    for (int i = 0; i < 60; i++) begin
      h = 16'($urandom);
      run_job(h, 1, -1, lat);
    end
    for (int i = 0; i < 20; i++) begin
      h = 16'($urandom);
      run_job(h, 0, -1, lat);
      chk("rand_lat", lat, 7 + nshift(h));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/flt2fix_seq.md
Name: flt2fix_seq

Overview:
- Hardware sequencer that converts an IEEE half-precision float in byte-wide data memory into signed 8.8 fixed point and writes the result back.
- Runs the same job as the software flt2fix program as a memory-mapped accelerator next to data_mem.
- Started by a start pulse and reports through a done level, matching the core's start/done handshake.
- Shares the single data-memory port through a req/gnt handshake.

Parameters:
- SRC_ADDR, 4, byte address of the float's low byte; the high byte is at SRC_ADDR+1.
- DST_ADDR, 6, byte address of the result's low byte; the high byte is at DST_ADDR+1.
- AW, 8, data-memory address width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle start request.
- done  out  1  level; high from job completion until the next accepted start.
- busy  out  1  high while a job is in progress (state not IDLE/DONE).
- mem_req  out  1  high in every state that needs the memory port.
- mem_gnt  in  1  port granted this cycle; the access happens only when req&gnt.
- mem_addr  out  AW  byte address.
- mem_rd_data  in  8  combinational read data for mem_addr.
- mem_wr_en  out  1  write strobe, asserted only when mem_gnt=1.
- mem_wr_data  out  8  write byte.

Behaviour:
- Reset values: state IDLE; done=0, busy=0, mem_req=0, mem_wr_en=0; mem_addr=0, mem_wr_data=0; all internal registers 0.
- Reset asserted mid-job aborts the job immediately. No further memory writes occur after reset asserts.
- States: IDLE, RD_LO, RD_HI, CLASSIFY, SHIFT, SIGN, WR_LO, WR_HI, DONE.
- start is accepted only in IDLE or DONE. In an accepting state, start=1 clears done and moves to RD_LO. start in any other state is ignored.
- RD_LO (addr SRC_ADDR) and RD_HI (addr SRC_ADDR+1): latch the byte on a cycle where gnt=1; otherwise hold state and address.
- CLASSIFY:
  - s = sign bit, e = exponent[4:0], m = {|e, frac[9:0]} (11 bits).
  - If e>=23 (unbiased exponent >= 8): load the saturation value, n=0.
  - Else if e>=17: magnitude = m, left-shift count n = e-17 (0..5).
  - Else: right-shift count n = 17-e. If n>12, magnitude = 0 and n = 0.
- SHIFT:
  - Shifts the 16-bit magnitude one bit per cycle and decrements n.
  - Exits to SIGN when n reaches 0. SHIFT is skipped entirely when n=0.
  - Right shifts truncate toward zero.
- SIGN:
  - If magnitude > 0x7FFF: result = 0x8000 when s=1 and magnitude==0x8000; otherwise saturate to 0x7FFF (s=0) or 0x8000 (s=1).
  - Else result = s ? -magnitude : magnitude, in 16-bit two's complement. -0 yields 0x0000.
  - Saturation value from CLASSIFY: 0x7FFF (s=0) or 0x8000 (s=1).
- WR_LO writes result[7:0] to DST_ADDR; WR_HI writes result[15:8] to DST_ADDR+1. Each write happens only when gnt=1; otherwise the state stalls.
- DONE: done=1 and busy=0, held until the next accepted start.
- Latency with gnt tied high: done rises 7+n clock edges after the edge that sampled start.
- mem_req is deasserted in IDLE, CLASSIFY, SHIFT, SIGN and DONE.
- Denormals (e=0) use hidden bit 0. Inf/NaN (e=31) saturate by sign.

Optional Feature:
- Macro: FLT2FIX_ROUND_EN.
- Defined:
  - SHIFT also tracks a guard bit (last bit shifted out) and a sticky bit (OR of all earlier shifted-out bits).
  - SIGN rounds the magnitude to nearest, ties to even, before negation.
  - The n>12 clamp still yields 0.
  - Rounding adds no extra cycles.
- Undefined: pure truncation toward zero; guard/sticky logic is absent.

Test Plan:
- mem[5:4]=0x3C00 (1.0), gnt=1, pulse start -> 0x00 written to mem[6], 0x01 to mem[7]; done exactly 9 edges after the start edge.
- 0x3D00 (1.25) -> 0x0140; 0xBC00 (-1.0) -> 0xFF00; 0x4400 (4.0) -> 0x0400 with done after 7 edges.
- 0x5B00 -> 0x7FFF; 0xD800 (-128.0) -> 0x8000; 0x7800 (e=30) -> 0x7FFF; 0xF800 -> 0x8000; 0x8000 (-0) -> 0x0000; 0x0001 -> 0x0000.
- 0x1E00 (1.5 lsb) -> 0x0001 without macro, 0x0002 with FLT2FIX_ROUND_EN.
- Hold gnt=0 for 3 cycles during RD_HI and during WR_LO -> no mem_wr_en while gnt=0; correct result; latency grows by exactly 6.
- Assert reset during SHIFT -> outputs return to reset values immediately and mem[7:6] stay unchanged. A start pulse during busy is ignored, and a start in DONE begins a new job with done dropping on the next edge.
